// File: rtl/dual_ram_clr.sv
// Single-port-write / single-port-read RAM with byte enables and a self-clearing
// start-up sequence. Optional same-address write-to-read forwarding: DUAL_RAM_CLR_BYPASS_EN.
module dual_ram_clr #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 4,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_L   = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Byte-lane merge: lanes with be set come from new_w, the rest from old_w.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              busy_r;
  logic [DATA_W-1:0] data_out_r;
  logic              rd_valid_r;
  logic              err_r;

  logic              clr_en_s;
  logic              rdy_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              wr_req_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] rd_data_s;

  // State register, clear pointer and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= '0;
      busy_r    <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
      if (clr_en_s) begin
        clr_ptr_r <= (clr_ptr_r == LAST_L) ? '0 : clr_ptr_r + ONE_L;
      end else begin
        clr_ptr_r <= clr_ptr_r;
      end
    end
  end

  // Next-state logic: CLEAR runs until the last word has been zeroed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_ptr_r == LAST_L) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_CLEAR;
    endcase
  end

  // State decode into clear and access enables.
  always_comb begin
    clr_en_s = 1'b0;
    rdy_s    = 1'b0;
    case (state_r)
      ST_CLEAR: clr_en_s = !reset;
      ST_READY: rdy_s    = !reset;
      default: begin
        clr_en_s = 1'b0;
        rdy_s    = 1'b0;
      end
    endcase
  end

  // Address range checks, request qualification and read-port data selection.
  always_comb begin
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    wr_req_s      = rdy_s & write;
    wr_ok_s       = wr_req_s & wr_in_range_s;
    rd_ok_s       = rdy_s & read;
    if (rd_in_range_s) begin
      rd_word_s = mem[rd_addr];
    end else begin
      rd_word_s = '0;
    end
`ifdef DUAL_RAM_CLR_BYPASS_EN
    if (wr_ok_s && (wr_addr == rd_addr)) begin
      rd_data_s = merge_lanes(rd_word_s, data_in, wr_be);
    end else begin
      rd_data_s = rd_word_s;
    end
`else
    rd_data_s = rd_word_s;
`endif
  end

  // Storage array: clear sequence has the port during CLEAR, user writes afterwards.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      mem[clr_ptr_r] <= '0;
    end else if (wr_ok_s) begin
      mem[wr_addr] <= merge_lanes(mem[wr_addr], data_in, wr_be);
    end
  end

  // Read data, valid pulse and sticky out-of-range error.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= '0;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rd_valid_r <= rd_ok_s;
      if (rd_ok_s) begin
        data_out_r <= rd_data_s;
      end else begin
        data_out_r <= data_out_r;
      end
      if ((rd_ok_s && !rd_in_range_s) || (wr_req_s && !wr_in_range_s)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign data_out = data_out_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule

// File: tb/tb_dual_ram_clr.sv
// Directed self-checking bench for dual_ram_clr (DATA_W=16, DEPTH=12, ADDR_W=4).
// Expects the same-address result for DUAL_RAM_CLR_BYPASS_EN according to the build.
module tb_dual_ram_clr;

  logic        clk;
  logic        reset;
  logic        write;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] data_in;
  logic        read;
  logic [3:0]  rd_addr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        busy;
  logic        err;

  int tests_run;
  int tests_failed;

  dual_ram_clr #(.DATA_W(16), .DEPTH(12), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .write(write), .wr_addr(wr_addr), .wr_be(wr_be),
    .data_in(data_in), .read(read), .rd_addr(rd_addr), .data_out(data_out),
    .rd_valid(rd_valid), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
    write = 1'b1; wr_addr = a; wr_be = be; data_in = d;
    tick();
    write = 1'b0; wr_be = 2'b00;
  endtask

  task automatic do_read(input logic [3:0] a);
    read = 1'b1; rd_addr = a;
    tick();
    read = 1'b0;
  endtask

  // Counts busy-high cycles while hammering read/write at addr 5; checks outputs stay idle.
  task automatic count_busy(output int cnt);
    cnt = 0;
    write = 1'b1; wr_addr = 4'd5; wr_be = 2'b11; data_in = 16'hFFFF;
    read = 1'b1; rd_addr = 4'd5;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tests_run++;
      if (rd_valid !== 1'b0 || data_out !== 16'h0000) begin
        tests_failed++;
        $display("FAIL clear_idle: rd_valid=%b data_out=%h, required 0 / 0000", rd_valid, data_out);
      end
      tick();
    end
    write = 1'b0; read = 1'b0; wr_be = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || err !== 1'b0 || data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b rd_valid=%b err=%b data_out=%h, required 1 0 0 0000",
               busy, rd_valid, err, data_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_clear();
    int cnt;
    count_busy(cnt);
    tests_run++;
    if (cnt !== 12) begin
      tests_failed++;
      $display("FAIL clear_length: busy cycles=%0d, required 12", cnt);
    end
    for (int i = 0; i < 12; i++) begin
      do_read(4'(i));
      tests_run++;
      if (rd_valid !== 1'b1 || data_out !== 16'h0000) begin
        tests_failed++;
        $display("FAIL zero_read[%0d]: rd_valid=%b data_out=%h, required 1 0000", i, rd_valid, data_out);
      end
      tick();
      tests_run++;
      if (rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_pulse[%0d]: rd_valid=%b, required 0", i, rd_valid);
      end
    end
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 2'b11, 16'hABCD);
    do_write(4'd3, 2'b01, 16'h12FF);
    do_read(4'd3);
    tests_run++;
    if (rd_valid !== 1'b1 || data_out !== 16'hABFF) begin
      tests_failed++;
      $display("FAIL be_low_lane: rd_valid=%b data_out=%h, required 1 ABFF", rd_valid, data_out);
    end
    do_write(4'd3, 2'b00, 16'h0000);
    do_read(4'd3);
    tests_run++;
    if (data_out !== 16'hABFF) begin
      tests_failed++;
      $display("FAIL be_none: data_out=%h, required ABFF", data_out);
    end
    do_write(4'd3, 2'b10, 16'h7711);
    do_read(4'd3);
    tests_run++;
    if (data_out !== 16'h77FF) begin
      tests_failed++;
      $display("FAIL be_high_lane: data_out=%h, required 77FF", data_out);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_fwd;
`ifdef DUAL_RAM_CLR_BYPASS_EN
    exp_fwd = 16'h5555;
`else
    exp_fwd = 16'h0000;
`endif
    write = 1'b1; wr_addr = 4'd7; wr_be = 2'b11; data_in = 16'h5555;
    read = 1'b1; rd_addr = 4'd7;
    tick();
    write = 1'b0; read = 1'b0; wr_be = 2'b00;
    tests_run++;
    if (rd_valid !== 1'b1 || data_out !== exp_fwd) begin
      tests_failed++;
      $display("FAIL same_addr: rd_valid=%b data_out=%h, required 1 %h", rd_valid, data_out, exp_fwd);
    end
    do_read(4'd7);
    tests_run++;
    if (data_out !== 16'h5555) begin
      tests_failed++;
      $display("FAIL same_addr_stored: data_out=%h, required 5555", data_out);
    end
    write = 1'b1; wr_addr = 4'd8; wr_be = 2'b11; data_in = 16'h1234;
    read = 1'b1; rd_addr = 4'd3;
    tick();
    write = 1'b0; read = 1'b0; wr_be = 2'b00;
    tests_run++;
    if (rd_valid !== 1'b1 || data_out !== 16'h77FF) begin
      tests_failed++;
      $display("FAIL diff_addr_read: rd_valid=%b data_out=%h, required 1 77FF", rd_valid, data_out);
    end
    do_read(4'd8);
    tests_run++;
    if (data_out !== 16'h1234) begin
      tests_failed++;
      $display("FAIL diff_addr_write: data_out=%h, required 1234", data_out);
    end
  endtask

  task automatic test_out_of_range();
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_initial: err=%b, required 0", err);
    end
    do_write(4'd13, 2'b11, 16'hBEEF);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_write: err=%b, required 1", err);
    end
    do_read(4'd14);
    tests_run++;
    if (rd_valid !== 1'b1 || data_out !== 16'h0000 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_read: rd_valid=%b data_out=%h err=%b, required 1 0000 1", rd_valid, data_out, err);
    end
    do_read(4'd1);
    tests_run++;
    if (data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL oor_alias1: data_out=%h, required 0000", data_out);
    end
    do_read(4'd5);
    tests_run++;
    if (data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL oor_alias5: data_out=%h, required 0000", data_out);
    end
    repeat (3) tick();
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
  endtask

  task automatic test_hold();
    int pulses;
    do_write(4'd2, 2'b11, 16'h2468);
    do_read(4'd2);
    pulses = (rd_valid === 1'b1) ? 1 : 0;
    tests_run++;
    if (data_out !== 16'h2468) begin
      tests_failed++;
      $display("FAIL hold_read: data_out=%h, required 2468", data_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_valid === 1'b1) pulses++;
      tests_run++;
      if (data_out !== 16'h2468) begin
        tests_failed++;
        $display("FAIL hold_data[%0d]: data_out=%h, required 2468", i, data_out);
      end
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL hold_pulses: rd_valid high cycles=%0d, required 1", pulses);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    reset = 1'b1; read = 1'b1; rd_addr = 4'd2;
    tick();
    read = 1'b0; reset = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || data_out !== 16'h0000 || err !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: rd_valid=%b data_out=%h err=%b busy=%b, required 0 0000 0 1",
               rd_valid, data_out, err, busy);
    end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(cnt);
    tests_run++;
    if (cnt !== 12) begin
      tests_failed++;
      $display("FAIL restart_length: busy cycles=%0d, required 12", cnt);
    end
    do_read(4'd5);
    tests_run++;
    if (rd_valid !== 1'b1 || data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL busy_write_dropped: rd_valid=%b data_out=%h, required 1 0000", rd_valid, data_out);
    end
    do_read(4'd2);
    tests_run++;
    if (data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rezeroed: data_out=%h, required 0000", data_out);
    end
    do_read(4'd8);
    tests_run++;
    if (data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rezeroed8: data_out=%h, required 0000", data_out);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b0; write = 1'b0; wr_addr = 4'd0; wr_be = 2'b00; data_in = 16'h0000;
    read = 1'b0; rd_addr = 4'd0;
    @(negedge clk);
    test_reset();
    test_clear();
    test_byte_enable();
    test_same_cycle();
    test_out_of_range();
    test_hold();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
